// File: rtl/gate_stim_pkg.sv
`default_nettype none
// ============================================================================
// Module      : gate_stim_pkg
// Description : Shared types, mode encodings and LFSR step for the gate
//               stimulus generator.
// Revision    : 1.0 - initial release
// ============================================================================
package gate_stim_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic        MODE_EXH     = 1'b0;
    localparam logic        MODE_RND     = 1'b1;

    localparam logic [15:0] LFSR_TAPS    = 16'hB400;
    localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

    // Right-shifting Galois form of x^16 + x^14 + x^13 + x^11 + 1.
    function automatic logic [15:0] lfsr_step(input logic [15:0] cur);
        return (cur >> 1) ^ (cur[0] ? LFSR_TAPS : 16'h0000);
    endfunction

endpackage
`default_nettype wire

// File: rtl/lfsr16.sv
`default_nettype none
// ============================================================================
// Module      : lfsr16
// Description : 16-bit Galois LFSR with synchronous seed load and step enable.
// Revision    : 1.0 - initial release
// ============================================================================
module lfsr16
    import gate_stim_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [15:0] seed,
    input  logic        advance,
    output logic [15:0] state
);

    logic [15:0] r_state;

    // Load wins over advance so a new run always begins exactly at the seed.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= seed;
        end else if (load) begin
            r_state <= seed;
        end else if (advance) begin
            r_state <= lfsr_step(r_state);
        end
    end

    assign state = r_state;

endmodule
`default_nettype wire

// File: rtl/gate_stim_gen.sv
`default_nettype none
// ============================================================================
// Module      : gate_stim_gen
// Description : Bounded {a, b} operand stream (exhaustive or LFSR-random) over
//               valid/ready, bracketed by a start/done handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module gate_stim_gen
    import gate_stim_pkg::*;
#(
    parameter logic [15:0] SEED  = DEFAULT_SEED,
    parameter int          CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mode,
    input  logic [CNT_W-1:0] num_vec,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             a,
    output logic             b,
    output logic [CNT_W-1:0] vec_idx,
    output logic             busy,
    output logic             done
);

    state_t             r_state;
    logic               r_mode;
    logic [CNT_W-1:0]   r_num_vec;
    logic [CNT_W-1:0]   r_vec_idx;
    logic               r_out_valid;
    logic               r_a;
    logic               r_b;
    logic               r_busy;
    logic               r_done;

    logic [15:0]        w_lfsr;
    logic [15:0]        w_lfsr_nxt;
    logic               w_start_acc;
    logic               w_xfer;
    logic               w_last;
    logic               w_lfsr_adv;
    logic [CNT_W-1:0]   w_idx_nxt;

    assign w_start_acc = (r_state == IDLE) && start;
    assign w_xfer      = (r_state == RUN) && r_out_valid && out_ready;
    assign w_last      = (r_vec_idx == (r_num_vec - CNT_W'(1)));
    assign w_lfsr_adv  = w_xfer && !w_last && (r_mode == MODE_RND);
    assign w_idx_nxt   = r_vec_idx + CNT_W'(1);
    assign w_lfsr_nxt  = lfsr_step(w_lfsr);

    lfsr16 u_lfsr (
        .clk     (clk),
        .rst     (rst),
        .load    (w_start_acc),
        .seed    (SEED),
        .advance (w_lfsr_adv),
        .state   (w_lfsr)
    );

    // a/b are registered from the value the LFSR/index will hold next cycle,
    // so the presented vector always matches the current LFSR state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_mode      <= MODE_EXH;
            r_num_vec   <= '0;
            r_vec_idx   <= '0;
            r_out_valid <= 1'b0;
            r_a         <= 1'b0;
            r_b         <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_mode    <= mode;
                        r_num_vec <= num_vec;
                        r_vec_idx <= '0;
                        if (num_vec == '0) begin
                            r_state <= DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state     <= RUN;
                            r_out_valid <= 1'b1;
                            r_busy      <= 1'b1;
                            r_a         <= (mode == MODE_RND) ? SEED[0] : 1'b0;
                            r_b         <= (mode == MODE_RND) ? SEED[1] : 1'b0;
                        end
                    end
                end
                RUN: begin
                    if (w_xfer) begin
                        if (w_last) begin
                            r_state     <= DONE;
                            r_out_valid <= 1'b0;
                            r_busy      <= 1'b0;
                            r_done      <= 1'b1;
                            r_a         <= 1'b0;
                            r_b         <= 1'b0;
                        end else begin
                            r_vec_idx <= w_idx_nxt;
                            if (r_mode == MODE_RND) begin
                                r_a <= w_lfsr_nxt[0];
                                r_b <= w_lfsr_nxt[1];
                            end else begin
                                r_a <= w_idx_nxt[1];
                                r_b <= w_idx_nxt[0];
                            end
                        end
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state     <= IDLE;
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign out_valid = r_out_valid;
    assign a         = r_a;
    assign b         = r_b;
    assign vec_idx   = r_vec_idx;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_gate_stim_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_gate_stim_gen
// Description : Scoreboard bench for gate_stim_gen: expected vectors are
//               queued at start and popped on each accepted transfer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gate_stim_gen;

    logic       clk;
    logic       rst;
    logic       start;
    logic       mode;
    logic [7:0] num_vec;
    logic       out_valid;
    logic       out_ready;
    logic       a;
    logic       b;
    logic [7:0] vec_idx;
    logic       busy;
    logic       done;

    typedef struct {
        logic [7:0] idx;
        logic       a;
        logic       b;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks;
    int   n_fail;

    gate_stim_gen #(
        .SEED  (16'hACE1),
        .CNT_W (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .mode      (mode),
        .num_vec   (num_vec),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .a         (a),
        .b         (b),
        .vec_idx   (vec_idx),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference model: builds the expected vector list of one run.
    task automatic push_run(input logic m, input int n);
        logic [15:0] lfsr;
        logic [7:0]  iv;
        exp_t        e;
        lfsr = 16'hACE1;
        for (int i = 0; i < n; i++) begin
            iv    = 8'(i);
            e.idx = iv;
            if (m) begin
                e.a  = lfsr[0];
                e.b  = lfsr[1];
                lfsr = (lfsr >> 1) ^ (lfsr[0] ? 16'hB400 : 16'h0000);
            end else begin
                e.a = iv[1];
                e.b = iv[0];
            end
            exp_q.push_back(e);
        end
    endtask

    // Returns at the falling edge of cycle 1 (start sampled at edge 0).
    task automatic do_start(input logic m, input logic [7:0] n);
        @(negedge clk);
        start   = 1'b1;
        mode    = m;
        num_vec = n;
        @(negedge clk);
        start   = 1'b0;
        mode    = ~m;
        num_vec = ~n;
    endtask

    // Scoreboard consumer: drives out_ready, pops on transfer, times done.
    task automatic collect(input int max_cyc, input int stall_from, input int stall_len,
                           input int poke_cyc, input int rst_cyc, input bit rand_ready,
                           output int done_cyc, output int nvec);
        exp_t e;
        done_cyc = -1;
        nvec     = 0;
        for (int k = 1; k <= max_cyc; k++) begin
            if (rand_ready)
                out_ready = ($urandom_range(0, 3) != 0);
            else
                out_ready = !(k >= stall_from && k < stall_from + stall_len);
            start = (k == poke_cyc);
            if (k == poke_cyc) begin
                mode    = ~mode;
                num_vec = 8'd2;
            end
            rst = (k == rst_cyc);
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_vec: cycle %0d idx=%0d ab=%b%b, none expected",
                             k, vec_idx, a, b);
                end else begin
                    e = exp_q[0];
                    n_checks++;
                    if ({vec_idx, a, b, busy} !== {e.idx, e.a, e.b, 1'b1}) begin
                        n_fail++;
                        $display("FAIL vector: cycle %0d got idx=%0d ab=%b%b busy=%b, want idx=%0d ab=%b%b busy=1",
                                 k, vec_idx, a, b, busy, e.idx, e.a, e.b);
                    end
                    if (out_ready) begin
                        void'(exp_q.pop_front());
                        nvec++;
                    end
                end
            end
            if (done) begin
                n_checks++;
                if ({out_valid, busy} !== 2'b00) begin
                    n_fail++;
                    $display("FAIL done_outputs: out_valid=%b busy=%b during done, want 0 0",
                             out_valid, busy);
                end
                done_cyc = k;
            end
            if (k == rst_cyc) begin
                start = 1'b0;
                return;
            end
            @(negedge clk);
            if (done_cyc >= 0) begin
                n_checks++;
                if ({done, out_valid, busy} !== 3'b000) begin
                    n_fail++;
                    $display("FAIL post_done: done=%b out_valid=%b busy=%b, want 000",
                             done, out_valid, busy);
                end
                break;
            end
        end
        start     = 1'b0;
        out_ready = 1'b1;
        if (done_cyc < 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL timeout: no done within %0d cycles, got %0d vectors", max_cyc, nvec);
        end
    endtask

    task automatic check_run(input string name, input int done_cyc, input int want_done,
                             input int nvec, input int want_vec);
        n_checks++;
        if (done_cyc != want_done || nvec != want_vec || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s: done_cycle=%0d vectors=%0d left=%0d, want done_cycle=%0d vectors=%0d left=0",
                     name, done_cyc, nvec, exp_q.size(), want_done, want_vec);
        end
        exp_q.delete();
    endtask

    task automatic test_reset;
        rst       = 1'b1;
        start     = 1'b0;
        mode      = 1'b0;
        num_vec   = 8'd0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({out_valid, a, b, vec_idx, busy, done} !== 13'd0) begin
            n_fail++;
            $display("FAIL reset: valid=%b a=%b b=%b idx=%0d busy=%b done=%b, want all 0",
                     out_valid, a, b, vec_idx, busy, done);
        end
        rst = 1'b0;
    endtask

    task automatic test_exhaustive;
        int dc, nv;
        push_run(1'b0, 6);
        do_start(1'b0, 8'd6);
        collect(30, 0, 0, -1, -1, 1'b0, dc, nv);
        check_run("exhaustive6", dc, 7, nv, 6);
    endtask

    task automatic test_random;
        int dc, nv;
        for (int r = 0; r < 2; r++) begin
            push_run(1'b1, 2);
            do_start(1'b1, 8'd2);
            collect(30, 0, 0, -1, -1, 1'b0, dc, nv);
            check_run("random2", dc, 3, nv, 2);
        end
    endtask

    task automatic test_backpressure;
        int dc, nv;
        push_run(1'b0, 3);
        do_start(1'b0, 8'd3);
        collect(30, 2, 3, -1, -1, 1'b0, dc, nv);
        check_run("backpressure", dc, 7, nv, 3);
    endtask

    task automatic test_zero;
        int dc, nv;
        do_start(1'b0, 8'd0);
        collect(30, 0, 0, -1, -1, 1'b0, dc, nv);
        check_run("num_vec_zero", dc, 1, nv, 0);
    endtask

    task automatic test_start_in_run;
        int dc, nv;
        push_run(1'b0, 5);
        do_start(1'b0, 8'd5);
        collect(30, 0, 0, 2, -1, 1'b0, dc, nv);
        check_run("start_in_run", dc, 6, nv, 5);
    endtask

    task automatic test_reset_mid_run;
        int dc, nv;
        push_run(1'b1, 5);
        do_start(1'b1, 8'd5);
        collect(30, 0, 0, -1, 3, 1'b0, dc, nv);
        @(negedge clk);
        rst = 1'b0;
        n_checks++;
        if ({out_valid, busy, vec_idx, done} !== 11'd0) begin
            n_fail++;
            $display("FAIL mid_run_reset: valid=%b busy=%b idx=%0d done=%b, want all 0",
                     out_valid, busy, vec_idx, done);
        end
        exp_q.delete();
        push_run(1'b1, 5);
        do_start(1'b1, 8'd5);
        collect(30, 0, 0, -1, -1, 1'b0, dc, nv);
        check_run("after_reset", dc, 6, nv, 5);
    endtask

    task automatic test_back_to_back;
        int dc, nv;
        push_run(1'b1, 40);
        do_start(1'b1, 8'd40);
        collect(400, 0, 0, -1, -1, 1'b1, dc, nv);
        n_checks++;
        if (nv != 40 || exp_q.size() != 0 || dc < 41) begin
            n_fail++;
            $display("FAIL random_stall: vectors=%0d left=%0d done_cycle=%0d, want 40 0 >=41",
                     nv, exp_q.size(), dc);
        end
        exp_q.delete();
        push_run(1'b0, 9);
        do_start(1'b0, 8'd9);
        collect(60, 0, 0, -1, -1, 1'b0, dc, nv);
        check_run("exhaustive9", dc, 10, nv, 9);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_exhaustive();
        test_random();
        test_backpressure();
        test_zero();
        test_start_in_run();
        test_reset_mid_run();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/gate_stim_gen.md
Name: gate_stim_gen

Overview:
- Upstream stimulus stage for the AND/OR/XOR gate block. Produces a bounded stream of {a, b} operand pairs over a valid/ready handshake.
- Two modes: exhaustive counting (00, 01, 10, 11, repeating) or pseudo-random from a 16-bit Galois LFSR.
- A start/done handshake brackets each run, so a bench or controller can request N vectors and know when they have all been consumed.

Parameters:
- SEED, 16'hACE1, LFSR value reloaded on reset and on every accepted start; must be nonzero.
- CNT_W, 8, width of the vector count and index.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  run request; sampled only in IDLE.
- mode  in  1  0 = exhaustive, 1 = random; latched on accepted start.
- num_vec  in  CNT_W  number of vectors for the run; latched on accepted start.
- out_valid  out  1  a/b hold a vector.
- out_ready  in  1  consumer accepts the vector when out_valid && out_ready.
- a  out  1  operand a.
- b  out  1  operand b.
- vec_idx  out  CNT_W  index of the vector currently presented, 0-based.
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse at end of run.

Behaviour:
- Reset (rst=1 at clk edge):
  - state = IDLE; out_valid, a, b, vec_idx, busy, done = 0; LFSR = SEED.
  - Applies from any state and aborts a run in progress; no done pulse is issued.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 latches mode and num_vec, reloads LFSR = SEED, clears vec_idx.
  - If num_vec == 0, go to DONE. Otherwise go to RUN; out_valid rises on the cycle after start is sampled.
- RUN:
  - out_valid = 1, busy = 1.
  - Exhaustive mode: {a, b} = vec_idx[1:0], with a as the MSB.
  - Random mode: a = lfsr[0], b = lfsr[1].
  - Transfer occurs when out_valid && out_ready.
    - If vec_idx == num_vec-1: go to DONE; out_valid drops the next cycle.
    - Otherwise: vec_idx increments, and in random mode the LFSR advances once.
  - While out_ready = 0, a, b and vec_idx stay stable. The LFSR does not advance without a transfer.
- DONE: done = 1 for exactly one cycle, busy = 0, out_valid = 0; next state IDLE.
- LFSR step:
  - lsb = lfsr[0]; lfsr_next = (lfsr >> 1) ^ (lsb ? 16'hB400 : 16'h0000).
  - Polynomial x^16 + x^14 + x^13 + x^11 + 1, maximal length; a nonzero seed never reaches 0.
- start is ignored in RUN and DONE; no queuing.
- Throughput: one vector per cycle when out_ready is held high.
- Latency:
  - N vectors with out_ready tied high: start sampled at edge 0; vectors valid in cycles 1..N; done in cycle N+1.
  - num_vec = 0: done in cycle 1, with no out_valid.
- vec_idx has no wrap concern, since num_vec <= 2^CNT_W - 1. Exhaustive a/b wrap naturally every 4 vectors.
- Outputs are registered; there are no combinational paths from out_ready to out_valid, a or b.

Decomposition:
- Package gate_stim_pkg holds:
  - the state enum (IDLE, RUN, DONE);
  - mode constants MODE_EXH = 1'b0 and MODE_RND = 1'b1;
  - LFSR_TAPS = 16'hB400 and the default seed.
- One natural sub-module: lfsr16, with inputs clk, rst, load, seed, advance and output state. The top-level FSM, counter and output muxing stay in gate_stim_gen.

Test Plan:
- Exhaustive, num_vec=6, out_ready=1: {a,b} sequence 00, 01, 10, 11, 00, 01 with vec_idx 0..5 in consecutive cycles; done pulses the cycle after vector 5; busy low afterwards.
- Random, num_vec=2, SEED=16'hACE1, out_ready=1: vector 0 is a=1, b=0 (lfsr=ACE1); vector 1 is a=0, b=0 (lfsr=E270); then done. A second start reproduces the identical sequence.
- Backpressure: exhaustive, num_vec=3, out_ready low for 3 cycles during vector 1. a/b stay at 01 and vec_idx at 1 throughout; no vector is skipped or duplicated; done arrives 3 cycles later than in the unstalled case.
- num_vec=0 with start: out_valid never rises; done pulses in cycle 1; FSM returns to IDLE.
- start pulsed again during RUN: ignored; the run completes with the original num_vec and mode.
- rst asserted mid-run at vector 2 of 5: the next cycle has out_valid=0, busy=0, vec_idx=0 and no done pulse. A subsequent start runs a full fresh sequence from SEED.
